// File: rtl/tr_pkg.sv
// Shared definitions for the tracking-mode step generator.
package tr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_TRACK   = 3'd1,
    ST_REVERSE = 3'd2,
    ST_HOLD    = 3'd3,
    ST_SETUP   = 3'd4
  } tr_state_t;

  // drv_dir polarity: positive means the carriage must move toward larger x
  localparam logic DIR_POS = 1'b1;
  localparam logic DIR_NEG = 1'b0;

endpackage

// File: rtl/tr_step_pulse.sv
// Step period counter: shapes the step pulse, flags the period wrap and
// slews the period n toward its target by at most ACC_STEP per step.
module tr_step_pulse #(
  parameter int WIDTH_WORK = 16,
  parameter int PULSE_W    = 8,
  parameter int ACC_STEP   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic                  load,
  input  logic [WIDTH_WORK-1:0] f1,
  input  logic [WIDTH_WORK-1:0] target,
  output logic [WIDTH_WORK-1:0] n,
  output logic                  step,
  output logic                  wrap
);

  localparam logic [WIDTH_WORK-1:0] ONE     = WIDTH_WORK'(1);
  localparam logic [WIDTH_WORK-1:0] PULSE_V = WIDTH_WORK'(PULSE_W);
  localparam logic [WIDTH_WORK-1:0] ACC_V   = WIDTH_WORK'(ACC_STEP);

  logic [WIDTH_WORK-1:0] p;
  logic [WIDTH_WORK-1:0] n_next;

  assign wrap = run && (p == n - ONE);
  assign step = run && (p < PULSE_V);

  // Next period: move toward target, limited to ACC_STEP per step
  always_comb begin
    n_next = target;
    if (target > n) begin
      if (target - n > ACC_V) n_next = n + ACC_V;
    end else if (n - target > ACC_V) begin
      n_next = n - ACC_V;
    end
  end

  // Period counter and period register; n only changes at a wrap so p never overruns it
  always_ff @(posedge clk) begin
    if (rst) begin
      p <= '0;
      n <= '0;
    end else if (load) begin
      p <= '0;
      n <= f1;
    end else if (run) begin
      if (wrap) begin
        p <= '0;
        n <= n_next;
      end else begin
        p <= p + ONE;
      end
    end
  end

endmodule

// File: rtl/tr_step_gen.sv
// Tracking-mode stepper controller: samples |x-x0|, maps it to a step period,
// and sequences the driver through deadzone hold and safe direction reversal.
//
// state   | meaning
// IDLE    | tracking disabled, driver off
// TRACK   | stepping toward x0 at ramped period n
// REVERSE | direction change requested: slow down to F1 in old direction
// HOLD    | inside deadzone, driver off until dx reaches DZ_EXIT
// SETUP   | direction settle time, no steps, then TRACK from F1
module tr_step_gen
  import tr_pkg::*;
#(
  parameter int WIDTH_IN   = 12,
  parameter int WIDTH_WORK = 16,
  parameter int DZ_ENTER   = 0,
  parameter int DZ_EXIT    = 50,
  parameter int L_SHIFT    = 4,
  parameter int PULSE_W    = 8,
  parameter int ACC_STEP   = 16,
  parameter int DIR_SETUP  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_valid,
  input  logic                  tr_mode_enable,
  input  logic [WIDTH_IN-1:0]   x0,
  input  logic [WIDTH_WORK-1:0] x,
  input  logic [WIDTH_WORK-1:0] dx1,
  input  logic [WIDTH_WORK-1:0] dx2,
  input  logic [WIDTH_WORK-1:0] F1,
  input  logic [WIDTH_WORK-1:0] F2,
  input  logic [WIDTH_WORK-1:0] k,
  output logic [WIDTH_WORK-1:0] n,
  output logic                  drv_step,
  output logic                  drv_dir,
  output logic                  drv_enable_SM,
  output logic [2:0]            state_o
);

  localparam int W  = WIDTH_WORK;
  localparam int CW = $clog2(DIR_SETUP + 1);
  localparam logic [W-1:0]  T_MIN_V    = W'(2 * PULSE_W);
  localparam logic [W-1:0]  DZ_ENTER_V = W'(DZ_ENTER);
  localparam logic [W-1:0]  DZ_EXIT_V  = W'(DZ_EXIT);
  localparam logic [CW-1:0] SETUP_LAST = CW'(DIR_SETUP - 1);

  logic [W-1:0]   x0_ext, dx_c, tgt_c;
  logic           dir_c;
  logic [2*W-1:0] prod, slope, span;

  logic [W-1:0] dx_r, tgt_r, f1_r;
  logic         dir_r;

  tr_state_t     state_q, state_d;
  logic          dir_q, dir_d, en_q, en_d, load;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          run, step_raw, wrap, dz_in;
  logic [W-1:0]  pulse_tgt;

  assign x0_ext = {{(W-WIDTH_IN){1'b0}}, x0};
  assign dx_c   = (x >= x0_ext) ? (x - x0_ext) : (x0_ext - x);
  assign dir_c  = (x <= x0_ext) ? DIR_POS : DIR_NEG;
  assign prod   = {{W{1'b0}}, k} * {{W{1'b0}}, dx_c - dx1};
  assign slope  = prod >> L_SHIFT;
  assign span   = {{W{1'b0}}, F1 - F2};

  // Piecewise-linear period target, floored at F2 on the slope and at T_MIN overall
  always_comb begin
    tgt_c = F1;
    if (dx_c >= dx2) begin
      tgt_c = F2;
    end else if (dx_c >= dx1) begin
      tgt_c = (slope >= span) ? F2 : (F1 - slope[W-1:0]);
    end
    if (tgt_c < T_MIN_V) tgt_c = T_MIN_V;
  end

  // Sample registers: everything the FSM and ramp use is frozen between strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      dx_r  <= '0;
      dir_r <= 1'b0;
      tgt_r <= '0;
      f1_r  <= '0;
    end else if (data_valid) begin
      dx_r  <= dx_c;
      dir_r <= dir_c;
      tgt_r <= tgt_c;
      f1_r  <= F1;
    end
  end

  assign run       = (state_q == ST_TRACK) || (state_q == ST_REVERSE);
  assign dz_in     = (dx_r <= DZ_ENTER_V);
  assign pulse_tgt = (state_q == ST_REVERSE) ? f1_r : tgt_r;

  tr_step_pulse #(
    .WIDTH_WORK (W),
    .PULSE_W    (PULSE_W),
    .ACC_STEP   (ACC_STEP)
  ) u_pulse (
    .clk    (clk),
    .rst    (rst),
    .run    (run),
    .load   (load),
    .f1     (f1_r),
    .target (pulse_tgt),
    .n      (n),
    .step   (step_raw),
    .wrap   (wrap)
  );

  // FSM state, direction, enable and settle counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dir_q   <= 1'b0;
      en_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      en_q    <= en_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; disable wins over everything, deadzone entry over reversal
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    en_d    = en_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    if (!tr_mode_enable) begin
      state_d = ST_IDLE;
      en_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (dz_in) begin
            state_d = ST_HOLD;
            en_d    = 1'b0;
          end else begin
            state_d = ST_SETUP;
            dir_d   = dir_r;
            en_d    = 1'b1;
            cnt_d   = SETUP_LAST;
          end
        end
        ST_TRACK: begin
          if (dz_in) begin
            state_d = ST_HOLD;
            en_d    = 1'b0;
          end else if (dir_r != dir_q) begin
            state_d = ST_REVERSE;
          end
        end
        ST_REVERSE: begin
          if (dz_in) begin
            state_d = ST_HOLD;
            en_d    = 1'b0;
          end else if (wrap && (n == f1_r)) begin
            state_d = ST_SETUP;
            dir_d   = ~dir_q;
            cnt_d   = SETUP_LAST;
          end
        end
        ST_HOLD: begin
          if (dx_r >= DZ_EXIT_V) begin
            state_d = ST_SETUP;
            dir_d   = dir_r;
            en_d    = 1'b1;
            cnt_d   = SETUP_LAST;
          end
        end
        ST_SETUP: begin
          if (cnt_q == '0) begin
            state_d = ST_TRACK;
            load    = 1'b1;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Disable gates the pins combinationally so a pulse in flight is cut at once
  assign drv_step      = step_raw & tr_mode_enable;
  assign drv_enable_SM = en_q & tr_mode_enable;
  assign drv_dir       = dir_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_tr_step_gen.sv
// Bench for tr_step_gen: expected step periods are queued when a sample is
// driven and compared against measured rise-to-rise intervals.
module tb_tr_step_gen;
  import tr_pkg::*;

  logic        clk = 1'b0;
  logic        rst, data_valid, tr_mode_enable;
  logic [11:0] x0;
  logic [15:0] x, dx1, dx2, F1, F2, k, n;
  logic        drv_step, drv_dir, drv_enable_SM;
  logic [2:0]  state_o;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];
  bit mon_on = 1'b0;
  int cyc = 0;

  bit mon_prev = 1'b0;
  bit mon_have = 1'b0;
  int mon_last = 0;
  int mon_hi   = 0;

  tr_step_gen dut (
    .clk            (clk),
    .rst            (rst),
    .data_valid     (data_valid),
    .tr_mode_enable (tr_mode_enable),
    .x0             (x0),
    .x              (x),
    .dx1            (dx1),
    .dx2            (dx2),
    .F1             (F1),
    .F2             (F2),
    .k              (k),
    .n              (n),
    .drv_step       (drv_step),
    .drv_dir        (drv_dir),
    .drv_enable_SM  (drv_enable_SM),
    .state_o        (state_o)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] xv, input logic [11:0] x0v);
    @(negedge clk);
    x = xv;
    x0 = x0v;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  task automatic wait_q(input string tag, input int budget);
    int i;
    i = 0;
    while (exp_q.size() > 0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk(tag, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Monitor: period between step rises and pulse width
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!mon_on) begin
        mon_prev = 1'b0;
        mon_have = 1'b0;
        mon_hi   = 0;
      end else begin
        if (drv_step) mon_hi++;
        if (drv_step && !mon_prev) begin
          if (mon_have && exp_q.size() > 0) chk("period", cyc - mon_last, exp_q.pop_front());
          mon_have = 1'b1;
          mon_last = cyc;
        end
        if (!drv_step && mon_prev) begin
          chk("pulse_w", mon_hi, 8);
          mon_hi = 0;
        end
        mon_prev = drv_step;
      end
    end
  end

  initial begin
    int cnt;
    rst = 1'b1; data_valid = 1'b0; tr_mode_enable = 1'b0;
    x = '0; x0 = '0; dx1 = 16'd100; dx2 = 16'd500; F1 = 16'd1000; F2 = 16'd100; k = 16'd32;
    repeat (4) @(negedge clk);
    chk("rst_n", n, 0);
    chk("rst_step", drv_step, 0);
    chk("rst_dir", drv_dir, 0);
    chk("rst_en", drv_enable_SM, 0);
    chk("rst_state", state_o, ST_IDLE);
    rst = 1'b0;

    // ramp from F1 toward slope target 600, direction positive
    @(negedge clk);
    tr_mode_enable = 1'b1;
    mon_on = 1'b1;
    for (int i = 0; i <= 25; i++) exp_q.push_back(1000 - 16 * i);
    exp_q.push_back(600);
    exp_q.push_back(600);
    send(16'd0, 12'd300);
    @(negedge clk);
    chk("b_state", state_o, ST_SETUP);
    chk("b_dir", drv_dir, 1);
    chk("b_en", drv_enable_SM, 1);
    cnt = 1;
    while (!drv_step && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    chk("b_setup_delay", cnt, 65);
    wait_q("b_ramp", 30000);
    chk("b_n", n, 600);

    // reversal: slow to F1 in old direction, settle, then track the other way
    exp_q.push_back(600);
    for (int i = 1; i <= 24; i++) exp_q.push_back(600 + 16 * i);
    exp_q.push_back(1000 + 64);
    exp_q.push_back(1000);
    exp_q.push_back(984);
    send(16'd900, 12'd100);
    @(negedge clk);
    chk("c_state", state_o, ST_REVERSE);
    chk("c_dir_old", drv_dir, 1);
    wait_q("c_ramp", 25000);
    chk("c_dir_new", drv_dir, 0);

    // disable while a pulse is high
    chk("d_pre_step", drv_step, 1);
    mon_on = 1'b0;
    tr_mode_enable = 1'b0;
    @(negedge clk);
    chk("d_step", drv_step, 0);
    chk("d_en", drv_enable_SM, 0);
    chk("d_state", state_o, ST_IDLE);

    // far from target: period floors at F2
    F1 = 16'd300;
    tr_mode_enable = 1'b1;
    mon_on = 1'b1;
    for (int i = 0; i <= 12; i++) exp_q.push_back(300 - 16 * i);
    repeat (3) exp_q.push_back(100);
    send(16'd900, 12'd100);
    wait_q("f_ramp", 8000);
    chk("f_n", n, 100);
    chk("f_dir", drv_dir, 0);

    // deadzone hysteresis
    mon_on = 1'b0;
    send(16'd100, 12'd100);
    @(negedge clk);
    chk("h_state", state_o, ST_HOLD);
    chk("h_step", drv_step, 0);
    chk("h_en", drv_enable_SM, 0);
    send(16'd130, 12'd100);
    repeat (3) @(negedge clk);
    chk("h_stay", state_o, ST_HOLD);
    send(16'd160, 12'd100);
    @(negedge clk);
    chk("h_resume", state_o, ST_SETUP);
    chk("h_en_on", drv_enable_SM, 1);
    chk("h_dir", drv_dir, 0);
    repeat (70) @(negedge clk);
    chk("h_track", state_o, ST_TRACK);
    chk("h_n", n, 300);

    // reset in the middle of a pulse
    cnt = 0;
    while (!drv_step && cnt < 1000) begin
      @(negedge clk);
      cnt++;
    end
    chk("r_pre_step", drv_step, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("r_step", drv_step, 0);
    chk("r_n", n, 0);
    chk("r_dir", drv_dir, 0);
    chk("r_en", drv_enable_SM, 0);
    chk("r_state", state_o, ST_IDLE);
    rst = 1'b0;
    cnt = 0;
    repeat (300) begin
      @(negedge clk);
      if (drv_step) cnt++;
    end
    chk("r_no_step", cnt, 0);
    chk("r_hold", state_o, ST_HOLD);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
